// File: rtl/rs_pipe_addsub_if.sv
// rs_pipe_addsub_if: valid/ready operand and result stream bundle.
// Carries the ovf wire only when RS_ADDSUB_OVF_EN is defined.
interface rs_pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             co;
`ifdef RS_ADDSUB_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, sub, ci, out_ready,
`ifdef RS_ADDSUB_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, y, co
  );

  modport master (
    output in_valid, a, b, sub, ci, out_ready,
`ifdef RS_ADDSUB_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, y, co
  );
endinterface

// File: rtl/rs_pipe_addsub.sv
// rs_pipe_addsub: adder/subtractor with the carry chain cut every SEG_W bits.
// Define RS_ADDSUB_OVF_EN to add the registered signed-overflow output.
module rs_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  rs_pipe_addsub_if.slave io
);
  localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             cin0;

  assign adv         = !io.out_valid || io.out_ready;
  assign io.in_ready = adv;
  assign bx          = io.sub ? ~io.b : io.b;
  assign cin0        = io.sub | io.ci;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int LO = k * SEG_W;
    localparam int HI = (LO + SEG_W > WIDTH) ? WIDTH - 1
                                             : LO + SEG_W - 1;
    localparam int SW = HI - LO + 1;

    logic [WIDTH-1:LO] oa;
    logic [WIDTH-1:LO] ob;
    logic              cin;
    logic              vin;
    logic [SW:0]       sum;
    logic [HI:0]       y_d;
    logic [HI:0]       y_q;
    logic              c_q;
    logic              v_q;

    if (k == 0) begin : g_src
      assign oa  = io.a;
      assign ob  = bx;
      assign cin = cin0;
      assign vin = io.in_valid;
      assign y_d = sum[SW-1:0];
    end else begin : g_src
      assign oa  = g_stg[k-1].g_skew.a_q;
      assign ob  = g_stg[k-1].g_skew.b_q;
      assign cin = g_stg[k-1].c_q;
      assign vin = g_stg[k-1].v_q;
      assign y_d = {sum[SW-1:0], g_stg[k-1].y_q};
    end

    assign sum = {1'b0, oa[HI:LO]}
               + {1'b0, ob[HI:LO]}
               + {{SW{1'b0}}, cin};

    // Segment result, carry and valid advance together
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        y_q <= y_d;
        c_q <= sum[SW];
        v_q <= vin;
      end
    end

    if (k < NSEG - 1) begin : g_skew
      logic [WIDTH-1:HI+1] a_q;
      logic [WIDTH-1:HI+1] b_q;

      // Delay the not-yet-added operand bits to the next stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= oa[WIDTH-1:HI+1];
          b_q <= ob[WIDTH-1:HI+1];
        end
      end
    end

`ifdef RS_ADDSUB_OVF_EN
    if (k == NSEG - 1) begin : g_ovf
      logic c_msb;
      logic ovf_q;

      assign c_msb = oa[HI] ^ ob[HI] ^ sum[SW-1];

      // Overflow is carry-into-MSB xor carry-out, aligned with y
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= c_msb ^ sum[SW];
        end
      end
    end
`endif
  end

  assign io.y         = g_stg[NSEG-1].y_q;
  assign io.co        = g_stg[NSEG-1].c_q;
  assign io.out_valid = g_stg[NSEG-1].v_q;
`ifdef RS_ADDSUB_OVF_EN
  assign io.ovf       = g_stg[NSEG-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_rs_pipe_addsub.sv
// tb_rs_pipe_addsub: directed checks of rs_pipe_addsub at WIDTH=32, SEG_W=8.
// ovf checks are compiled in with RS_ADDSUB_OVF_EN.
module tb_rs_pipe_addsub;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        ci;
    logic [31:0] y;
    logic        co;
    logic        ovf;
  } vec_t;

  localparam int NV = 14;

  vec_t tv [NV] = '{
    '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
    '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0},
    '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0},
    '{32'h00FF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b0},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1},
    '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1},
    '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0},
    '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_00FF, 1'b1, 1'b0},
    '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0}
  };

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   n_out;
  bit   pchk;
  bit   acc;
  logic [3:0] vpipe;
  vec_t sb [$];

  rs_pipe_addsub_if #(.WIDTH(32)) io ();

  rs_pipe_addsub #(
    .WIDTH (32),
    .SEG_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input vec_t t, input bit ordy);
    io.in_valid  = v;
    io.a         = t.a;
    io.b         = t.b;
    io.sub       = t.sub;
    io.ci        = t.ci;
    io.out_ready = ordy;
  endtask

  task automatic step(input bit v, input vec_t t, input bit ordy,
                      output bit accd);
    bit fo;
    @(negedge clk);
    drive(v, t, ordy);
    #1;
    accd = io.in_valid && io.in_ready;
    fo   = io.out_valid && ordy;
    if (pchk) chk("valid_pattern", 32'(io.out_valid), 32'(vpipe[3]));
    if (fo) begin
      if (sb.size() == 0) begin
        chk("extra_beat", 32'd0, 32'd1);
      end else begin
        chk("y", io.y, sb[0].y);
        chk("co", 32'(io.co), 32'(sb[0].co));
`ifdef RS_ADDSUB_OVF_EN
        chk("ovf", 32'(io.ovf), 32'(sb[0].ovf));
`endif
      end
    end
    @(posedge clk);
    if (fo && sb.size() > 0) void'(sb.pop_front());
    if (accd) sb.push_back(t);
    if (fo) n_out++;
    vpipe = {vpipe[2:0], accd};
  endtask

  initial begin
    int idx;
    int nacc;
    int nout0;
    n_chk = 0;
    n_err = 0;
    n_out = 0;
    pchk  = 1'b0;
    vpipe = '0;
    rst_n = 1'b0;
    drive(1'b0, tv[0], 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_y", io.y, 32'd0);
    chk("rst_co", 32'(io.co), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
`ifdef RS_ADDSUB_OVF_EN
    chk("rst_ovf", 32'(io.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Single beats: full carry ripple, then subtract with ci ignored
    pchk = 1'b1;
    step(1'b1, tv[0], 1'b1, acc);
    repeat (5) step(1'b0, tv[0], 1'b1, acc);
    step(1'b1, tv[1], 1'b1, acc);
    repeat (5) step(1'b0, tv[0], 1'b1, acc);

    // Back-to-back directed table
    for (int i = 0; i < NV; i++) step(1'b1, tv[i], 1'b1, acc);
    repeat (5) step(1'b0, tv[0], 1'b1, acc);

    // Random valid pattern over table vectors
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), tv[$urandom_range(0, NV - 1)],
           1'b1, acc);
    repeat (5) step(1'b0, tv[0], 1'b1, acc);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    // Backpressure: 10 cycles of out_ready low on a full pipe
    pchk  = 1'b0;
    idx   = 0;
    nacc  = 0;
    nout0 = n_out;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, tv[idx % NV], 1'b1, acc);
      if (acc) begin idx++; nacc++; end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, tv[idx % NV], 1'b0);
      #1;
      chk("stall_in_ready", 32'(io.in_ready), 32'd0);
      chk("stall_out_valid", 32'(io.out_valid), 32'd1);
      if (sb.size() > 0) chk("stall_y", io.y, sb[0].y);
      @(posedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tv[idx % NV], 1'b1, acc);
      if (acc) begin idx++; nacc++; end
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++)
      step(1'b0, tv[0], 1'b1, acc);
    chk("stall_drain", 32'(sb.size()), 32'd0);
    chk("stall_count", 32'(n_out - nout0), 32'(nacc));

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) step(1'b1, tv[i + 2], 1'b1, acc);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, tv[0], 1'b1);
    #1;
    chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("mid_rst_y", io.y, 32'd0);
    sb.delete();
    vpipe = '0;
    @(negedge clk);
    rst_n = 1'b1;
    pchk  = 1'b1;
    step(1'b1, tv[6], 1'b1, acc);
    repeat (7) step(1'b0, tv[0], 1'b1, acc);
    chk("post_rst_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
